// File: rtl/texture_frame_scanner.sv
// Texture frame scanner: sweeps every (x,y) of the frame once per start, issues
// the coordinate to a texture source, and forwards each reply to the frame
// buffer together with a running 16-bit checksum.
module texture_frame_scanner #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int TEX_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  tex_x,
  output logic [6:0]  tex_y,
  input  logic [15:0] tex_data,
  output logic        fb_we,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  output logic [15:0] frame_sum
);

  localparam int TOTAL = WIDTH * HEIGHT;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   vld_p0;
  logic [TEX_LATENCY-1:0] vld_p1;
  logic [12:0]            wr_cnt;
  logic                   last_coord;
  logic                   take;

  // Checksum accumulation: modulo-2^16 add, overflow discarded.
  function automatic logic [15:0] wrap_add16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  assign last_coord = (tex_x == 7'(WIDTH - 1)) && (tex_y == 7'(HEIGHT - 1));
  assign take       = vld_p1[TEX_LATENCY-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; DRAIN exits once the last pixel is on the bus.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_coord) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (fb_we && (wr_cnt == 13'(TOTAL))) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinate generation (p0), latency alignment (p1) and frame-buffer write stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      tex_x     <= '0;
      tex_y     <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      frame_sum <= '0;
      wr_cnt    <= '0;
    end else begin
      // p0 -> p1: valid follows the coordinate through the source latency
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < TEX_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];

      // p1 -> write: the reply is in order, so the address is just a running count
      fb_we <= take;
      if (take) begin
        fb_addr   <= wr_cnt;
        fb_data   <= tex_data;
        frame_sum <= wrap_add16(frame_sum, tex_data);
        wr_cnt    <= wr_cnt + 13'd1;
      end

      case (state)
        IDLE: begin
          vld_p0 <= 1'b0;
          if (start) begin
            tex_x     <= '0;
            tex_y     <= '0;
            vld_p0    <= 1'b1;
            frame_sum <= '0;
            wr_cnt    <= '0;
          end
        end
        SCAN: begin
          if (last_coord) begin
            vld_p0 <= 1'b0;
          end else begin
            vld_p0 <= 1'b1;
            if (tex_x == 7'(WIDTH - 1)) begin
              tex_x <= '0;
              tex_y <= tex_y + 7'd1;
            end else begin
              tex_x <= tex_x + 7'd1;
            end
          end
        end
        default: vld_p0 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_texture_frame_scanner.sv
// Directed bench: two scanners (latency 1 with a stripe source, latency 3 with a
// coordinate-echo source) driven by the same start/reset.
module tb_texture_frame_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic        a_busy, a_done, a_fb_we;
  logic [6:0]  a_tex_x, a_tex_y;
  logic [15:0] a_tex = '0;
  logic [12:0] a_fb_addr;
  logic [15:0] a_fb_data, a_frame_sum;

  logic        b_busy, b_done, b_fb_we;
  logic [6:0]  b_tex_x, b_tex_y;
  logic [15:0] b_tex = '0, b_d1 = '0, b_d2 = '0;
  logic [12:0] b_fb_addr;
  logic [15:0] b_fb_data, b_frame_sum;

  int cyc = 0;
  int e0 = 0;
  int run_id = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] b_exp_sum = '0;

  texture_frame_scanner #(.WIDTH(96), .HEIGHT(64), .TEX_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy), .done(a_done),
    .tex_x(a_tex_x), .tex_y(a_tex_y), .tex_data(a_tex), .fb_we(a_fb_we),
    .fb_addr(a_fb_addr), .fb_data(a_fb_data), .frame_sum(a_frame_sum));

  texture_frame_scanner #(.WIDTH(96), .HEIGHT(64), .TEX_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(b_busy), .done(b_done),
    .tex_x(b_tex_x), .tex_y(b_tex_y), .tex_data(b_tex), .fb_we(b_fb_we),
    .fb_addr(b_fb_addr), .fb_data(b_fb_data), .frame_sum(b_frame_sum));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Texture sources: floor stripe (1 cycle) and coordinate echo (3 cycles).
  always @(posedge clk) begin
    a_tex <= ((a_tex_y % 6) < 4) ? 16'h9A00 : 16'h5940;
    b_d1  <= {2'b00, b_tex_y, b_tex_x};
    b_d2  <= b_d1;
    b_tex <= b_d2;
  end

  // Monitor state
  int seen_run = 0;
  int a_wr, a_bad_ord, a_first, a_last, a_dcnt, a_dc1, a_dc2;
  int b_wr, b_bad_ord, b_bad_dat, b_first, b_last, b_dcnt, b_dc1, b_dc2;
  logic [15:0] a_d0, a_d384, a_d6143;
  logic a_pdone, b_pdone, a_busy_after, b_busy_after;

  always @(negedge clk) begin
    logic [15:0] bexp;
    if (seen_run != run_id) begin
      seen_run = run_id;
      a_wr = 0; a_bad_ord = 0; a_first = -1; a_last = -1; a_dcnt = 0; a_dc1 = -1; a_dc2 = -1;
      b_wr = 0; b_bad_ord = 0; b_bad_dat = 0; b_first = -1; b_last = -1; b_dcnt = 0; b_dc1 = -1; b_dc2 = -1;
      a_d0 = '0; a_d384 = '0; a_d6143 = '0;
      a_pdone = 1'b0; b_pdone = 1'b0; a_busy_after = 1'b1; b_busy_after = 1'b1;
    end
    if (a_fb_we) begin
      if (int'(a_fb_addr) != (a_wr % 6144)) a_bad_ord++;
      if (a_wr == 0) a_first = cyc - e0;
      a_last = cyc - e0;
      if (a_fb_addr == 13'd0)    a_d0    = a_fb_data;
      if (a_fb_addr == 13'd384)  a_d384  = a_fb_data;
      if (a_fb_addr == 13'd6143) a_d6143 = a_fb_data;
      a_wr++;
    end
    if (b_fb_we) begin
      if (int'(b_fb_addr) != (b_wr % 6144)) b_bad_ord++;
      bexp = {2'b00, 7'(int'(b_fb_addr) / 96), 7'(int'(b_fb_addr) % 96)};
      if (b_fb_data != bexp) b_bad_dat++;
      if (b_wr == 0) b_first = cyc - e0;
      b_last = cyc - e0;
      b_wr++;
    end
    if (a_pdone) a_busy_after = a_busy;
    if (b_pdone) b_busy_after = b_busy;
    a_pdone = a_done;
    b_pdone = b_done;
    if (a_done) begin
      if (a_dcnt == 0) a_dc1 = cyc - e0; else a_dc2 = cyc - e0;
      a_dcnt++;
    end
    if (b_done) begin
      if (b_dcnt == 0) b_dc1 = cyc - e0; else b_dc2 = cyc - e0;
      b_dcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // New statistics window, then start sampled at the following posedge (E0).
  task automatic begin_run();
    run_id++;
    repeat (2) @(negedge clk);
    start = 1'b1;
    e0 = cyc;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while ((a_dcnt < n || b_dcnt < n) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_count_a", a_dcnt, n);
    chk("done_count_b", b_dcnt, n);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_wr_a"},     a_wr, 6144);
    chk({tag, "_wr_b"},     b_wr, 6144);
    chk({tag, "_order_a"},  a_bad_ord, 0);
    chk({tag, "_order_b"},  b_bad_ord, 0);
    chk({tag, "_data_b"},   b_bad_dat, 0);
    chk({tag, "_contig_a"}, a_last - a_first + 1, a_wr);
    chk({tag, "_contig_b"}, b_last - b_first + 1, b_wr);
    chk({tag, "_first_a"},  a_first, 3);
    chk({tag, "_first_b"},  b_first, 5);
    chk({tag, "_donecyc_a"}, a_dc1, 6147);
    chk({tag, "_donecyc_b"}, b_dc1, 6149);
    chk({tag, "_busyoff_a"}, a_busy_after, 0);
    chk({tag, "_busyoff_b"}, b_busy_after, 0);
    chk({tag, "_sum_a"},    a_frame_sum, 16'h6000);
    chk({tag, "_sum_b"},    b_frame_sum, b_exp_sum);
  endtask

  initial begin
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 96; x++)
        b_exp_sum = b_exp_sum + {2'b00, 7'(y), 7'(x)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    chk("rst_we",    a_fb_we, 0);
    chk("rst_addr",  a_fb_addr, 0);
    chk("rst_data",  a_fb_data, 0);
    chk("rst_tex",   {a_tex_y, a_tex_x}, 0);
    chk("rst_sum",   a_frame_sum, 0);
    chk("rst_we_b",  b_fb_we, 0);
    reset = 1'b0;

    // Clean sweep with coordinate-sequence spot checks
    begin_run();
    @(negedge clk); start = 1'b0;
    chk("c1_busy", a_busy, 1);
    chk("c1_tex",  {a_tex_y, a_tex_x}, 14'h0000);
    @(negedge clk);
    chk("c2_tex",  {a_tex_y, a_tex_x}, {7'd0, 7'd1});
    while (cyc - e0 < 97) @(negedge clk);
    chk("c97_tex", {a_tex_y, a_tex_x}, {7'd1, 7'd0});
    wait_done(1, 7000);
    check_frame("clean");
    chk("px0",    a_d0,    16'h9A00);
    chk("px384",  a_d384,  16'h5940);
    chk("px6143", a_d6143, 16'h9A00);
    chk("hold_tex", {a_tex_y, a_tex_x}, {7'd63, 7'd95});

    // Start pulse mid-sweep is ignored
    begin_run();
    @(negedge clk); start = 1'b0;
    while (cyc - e0 < 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1, 7000);
    check_frame("midstart");

    // Reset mid-sweep
    begin_run();
    @(negedge clk); start = 1'b0;
    while (cyc - e0 < 3000) @(negedge clk);
    chk("pre_rst_we", a_fb_we, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_a",  a_fb_we, 0);
    chk("rst_mid_we_b",  b_fb_we, 0);
    chk("rst_mid_sum_a", a_frame_sum, 0);
    chk("rst_mid_sum_b", b_frame_sum, 0);
    chk("rst_mid_busy",  a_busy, 0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    chk("rst_nodone_a", a_dcnt, 0);
    chk("rst_nodone_b", b_dcnt, 0);
    begin_run();
    @(negedge clk); start = 1'b0;
    wait_done(1, 7000);
    check_frame("after_rst");

    // start held for 10000 cycles: back-to-back sweeps, one done each
    begin_run();
    repeat (10000) @(negedge clk);
    start = 1'b0;
    wait_done(2, 8000);
    chk("hold_done2_a", a_dc2, 12295);
    chk("hold_done2_b", b_dc2, 12299);
    chk("hold_wr_a",    a_wr, 12288);
    chk("hold_wr_b",    b_wr, 12288);
    chk("hold_order_a", a_bad_ord, 0);
    chk("hold_data_b",  b_bad_dat, 0);
    repeat (20) @(negedge clk);
    chk("hold_idle_a",  a_busy, 0);
    chk("hold_sum_a",   a_frame_sum, 16'h6000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
